// File: rtl/led_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_sched_pkg
//  Description : Shared types and constants for the shared-LED event scheduler
//  Revision    : 1.0 - initial release
// ============================================================================
package led_sched_pkg;

  // Playback states of the blink-code sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_e;

  // Default durations: 50 ms on / 50 ms off / 200 ms gap at 12.5 MHz.
  localparam int unsigned DEF_ON_CYCLES  = 625000;
  localparam int unsigned DEF_OFF_CYCLES = 625000;
  localparam int unsigned DEF_GAP_CYCLES = 2500000;

  // Ceiling log2, used to validate IDX_W and CNT_W at elaboration time.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_event_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker; searches from last+1
//                upward, wrapping, and returns the first set request.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan candidates in priority order; the first pending one wins.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!any && req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_event_sched.sv
`default_nettype none
// ============================================================================
//  Module      : led_event_sched
//  Description : Shares one active-low LED between NUM_REQ event sources.
//                Events latch as pending; a round-robin arbiter picks one
//                and the LED blinks (index+1) pulses followed by a gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_event_sched
  import led_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IDX_W      = 2,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = 22
) (
  input  logic               i_clk,
  input  logic               i_res,
  input  logic [NUM_REQ-1:0] i_trig,
  output logic               o_led,
  output logic               o_busy,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic [NUM_REQ-1:0] o_pending
);

  localparam int c_max_dur = (ON_CYCLES > OFF_CYCLES)
                           ? ((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES)
                           : ((OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES);

  localparam logic [CNT_W-1:0] c_on_load  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_off_load = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_load = CNT_W'(GAP_CYCLES - 1);

  // Elaboration-time sanity checks on the parameter set.
  if (IDX_W != clog2(NUM_REQ)) begin : g_chk_idx_w
    $error("led_event_sched: IDX_W must equal clog2(NUM_REQ)");
  end
  if (clog2(c_max_dur) > CNT_W) begin : g_chk_cnt_w
    $error("led_event_sched: CNT_W too narrow for longest duration");
  end

  led_state_e         r_state;
  led_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic [IDX_W-1:0]   r_blink_rem;
  logic [IDX_W-1:0]   w_blink_nxt;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] w_clr;
  logic               w_grant_load;
  logic               w_any;
  logic [IDX_W-1:0]   w_pick;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req  (r_pending),
    .last (r_last_grant),
    .any  (w_any),
    .idx  (w_pick)
  );

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, timer reload/decrement and grant decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_blink_nxt  = r_blink_rem;
    w_grant_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt  = ST_ON;
          w_timer_nxt  = c_on_load;
          w_blink_nxt  = w_pick;
          w_grant_load = 1'b1;
        end
      end
      ST_ON: begin
        if (r_timer == '0) begin
          if (r_blink_rem != '0) begin
            w_state_nxt = ST_OFF;
            w_timer_nxt = c_off_load;
          end else begin
            w_state_nxt = ST_GAP;
            w_timer_nxt = c_gap_load;
          end
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_ON;
          w_timer_nxt = c_on_load;
          w_blink_nxt = r_blink_rem - IDX_W'(1);
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-hot clear mask for the source being granted this cycle.
  always_comb begin
    w_clr = '0;
    if (w_grant_load) begin
      w_clr[w_pick] = 1'b1;
    end
  end

  // Datapath registers; a trigger on the grant edge re-arms the source.
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_timer      <= '0;
      r_blink_rem  <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_pending    <= '0;
    end else begin
      r_timer     <= w_timer_nxt;
      r_blink_rem <= w_blink_nxt;
      r_pending   <= (r_pending & ~w_clr) | i_trig;
      if (w_grant_load) begin
        r_last_grant <= w_pick;
        r_grant_idx  <= w_pick;
      end
    end
  end

  assign o_led       = (r_state != ST_ON);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_grant_idx = r_grant_idx;
  assign o_pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_led_event_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_event_sched
//  Description : Directed self-checking bench for led_event_sched with short
//                durations (ON=3, OFF=2, GAP=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_event_sched;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] trig;
  logic       led;
  logic       busy;
  logic [1:0] grant;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;

  led_event_sched #(
    .NUM_REQ    (4),
    .IDX_W      (2),
    .ON_CYCLES  (3),
    .OFF_CYCLES (2),
    .GAP_CYCLES (5),
    .CNT_W      (3)
  ) dut (
    .i_clk       (clk),
    .i_res       (res),
    .i_trig      (trig),
    .o_led       (led),
    .o_busy      (busy),
    .o_grant_idx (grant),
    .o_pending   (pending)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    res  = 1'b1;
    trig = 4'b0000;
    step();
    step();
    res = 1'b0;
    step();
  endtask

  // Observe one code: idle cycles before busy, grant, pulse count, busy length.
  task automatic play_code(output int idle_wait, output int idx, output int pulses,
                           output int blen, output bit timeout);
    logic prev;
    idle_wait = 0;
    idx       = -1;
    pulses    = 0;
    blen      = 0;
    timeout   = 1'b0;
    while (busy !== 1'b1 && idle_wait < 60) begin
      step();
      idle_wait++;
    end
    if (busy !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    idx  = int'(grant);
    prev = 1'b1;
    while (busy === 1'b1 && blen < 200) begin
      if (prev === 1'b1 && led === 1'b0) pulses++;
      prev = led;
      blen++;
      step();
    end
    if (busy === 1'b1) timeout = 1'b1;
  endtask

  task automatic test_reset();
    res  = 1'b1;
    trig = 4'b1111;
    step();
    step();
    total++; if (led !== 1'b1)        begin bad++; $display("FAIL reset_led got=%b want=1", led); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL reset_pending got=%b want=0000", pending); end
    total++; if (grant !== 2'd0)      begin bad++; $display("FAIL reset_grant got=%0d want=0", grant); end
    trig = 4'b0000;
    res  = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic exp_led;
    logic exp_busy;
    apply_reset();
    trig = 4'b0100;
    step();
    trig = 4'b0000;
    total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending got=%b want=0100", pending); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL single_busy_pre got=%b want=0", busy); end
    for (int k = 1; k <= 19; k++) begin
      step();
      exp_led  = !((k >= 1 && k <= 3) || (k >= 6 && k <= 8) || (k >= 11 && k <= 13));
      exp_busy = (k <= 18);
      total++; if (led !== exp_led)   begin bad++; $display("FAIL single_led k=%0d got=%b want=%b", k, led, exp_led); end
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL single_busy k=%0d got=%b want=%b", k, busy, exp_busy); end
      if (k == 1) begin
        total++; if (grant !== 2'd2)      begin bad++; $display("FAIL single_grant got=%0d want=2", grant); end
        total++; if (pending !== 4'b0000) begin bad++; $display("FAIL single_clear got=%b want=0000", pending); end
      end
    end
  endtask

  task automatic test_round_robin();
    int iw, idx, pul, bl;
    bit to;
    apply_reset();
    trig = 4'b1001;
    step();
    trig = 4'b0000;
    total++; if (pending !== 4'b1001) begin bad++; $display("FAIL rr_pending0 got=%b want=1001", pending); end
    step();
    total++; if (grant !== 2'd0)      begin bad++; $display("FAIL rr_first got=%0d want=0", grant); end
    total++; if (pending !== 4'b1000) begin bad++; $display("FAIL rr_pending1 got=%b want=1000", pending); end
    play_code(iw, idx, pul, bl, to);
    total++; if (to || pul != 1 || bl != 8) begin bad++; $display("FAIL rr_code0 got=to%0d/p%0d/l%0d want=to0/p1/l8", to, pul, bl); end
    play_code(iw, idx, pul, bl, to);
    total++; if (to || idx != 3 || iw != 1) begin bad++; $display("FAIL rr_second got=to%0d/i%0d/w%0d want=to0/i3/w1", to, idx, iw); end
    total++; if (pul != 4 || bl != 23)     begin bad++; $display("FAIL rr_code3 got=p%0d/l%0d want=p4/l23", pul, bl); end
    total++; if (pending !== 4'b0000)      begin bad++; $display("FAIL rr_pending2 got=%b want=0000", pending); end
  endtask

  task automatic test_fairness();
    int iw, idx, pul, bl;
    bit to;
    int exp_order[3] = '{2, 0, 1};
    apply_reset();
    trig = 4'b0010;
    step();
    trig = 4'b0000;
    play_code(iw, idx, pul, bl, to);
    total++; if (to || idx != 1) begin bad++; $display("FAIL fair_setup got=to%0d/i%0d want=to0/i1", to, idx); end
    trig = 4'b0111;
    step();
    trig = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      play_code(iw, idx, pul, bl, to);
      total++;
      if (to || idx != exp_order[i] || pul != exp_order[i] + 1 || iw != 1) begin
        bad++;
        $display("FAIL fair_code%0d got=to%0d/i%0d/p%0d/w%0d want=to0/i%0d/p%0d/w1",
                 i, to, idx, pul, iw, exp_order[i], exp_order[i] + 1);
      end
    end
  endtask

  // Trigger held for 10 edges: the grant edge re-arms the source, and the
  // replay is granted after the hold ends, so exactly two codes play.
  task automatic test_absorb_replay();
    int iw, idx, pul, bl;
    bit to;
    bit seen;
    apply_reset();
    trig = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        total++; if (pending !== 4'b0001 || busy !== 1'b0) begin bad++; $display("FAIL abs_first got=%b/%b want=0001/0", pending, busy); end
      end
      if (i == 1) begin
        total++; if (busy !== 1'b1 || grant !== 2'd0) begin bad++; $display("FAIL abs_grant got=%b/%0d want=1/0", busy, grant); end
        total++; if (pending !== 4'b0001) begin bad++; $display("FAIL abs_setwins got=%b want=0001", pending); end
      end
    end
    trig = 4'b0000;
    total++; if (busy !== 1'b0 || pending !== 4'b0001) begin bad++; $display("FAIL abs_idle got=%b/%b want=0/0001", busy, pending); end
    play_code(iw, idx, pul, bl, to);
    total++; if (to || iw != 1 || idx != 0 || pul != 1 || bl != 8) begin bad++; $display("FAIL abs_replay got=to%0d/w%0d/i%0d/p%0d/l%0d want=to0/w1/i0/p1/l8", to, iw, idx, pul, bl); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL abs_drained got=%b want=0000", pending); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL abs_no_third got=busy want=idle"); end
  endtask

  task automatic test_reset_mid();
    int iw, idx, pul, bl;
    bit to;
    apply_reset();
    trig = 4'b1000;
    step();
    trig = 4'b0000;
    step();
    total++; if (led !== 1'b0 || grant !== 2'd3) begin bad++; $display("FAIL mid_on got=%b/%0d want=0/3", led, grant); end
    trig = 4'b0001;
    step();
    trig = 4'b0000;
    total++; if (pending !== 4'b0001) begin bad++; $display("FAIL mid_pend got=%b want=0001", pending); end
    res = 1'b1;
    step();
    total++; if (led !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort got=%b/%b want=1/0", led, busy); end
    total++; if (pending !== 4'b0000 || grant !== 2'd0) begin bad++; $display("FAIL mid_clear got=%b/%0d want=0000/0", pending, grant); end
    res  = 1'b0;
    trig = 4'b0011;
    step();
    trig = 4'b0000;
    play_code(iw, idx, pul, bl, to);
    total++; if (to || idx != 0 || iw != 1) begin bad++; $display("FAIL mid_restart got=to%0d/i%0d/w%0d want=to0/i0/w1", to, idx, iw); end
    play_code(iw, idx, pul, bl, to);
    total++; if (to || idx != 1 || pul != 2) begin bad++; $display("FAIL mid_next got=to%0d/i%0d/p%0d want=to0/i1/p2", to, idx, pul); end
  endtask

  task automatic test_idle_quiet();
    int errs;
    apply_reset();
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (led !== 1'b1 || busy !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL idle_quiet got=%0d_bad_cycles want=0", errs); end
  endtask

  initial begin
    res  = 1'b1;
    trig = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_absorb_replay();
    test_reset_mid();
    test_idle_quiet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
